// File: rtl/piso_pkg.sv
// piso_pkg: shared state type and sizing helper for the PISO serializer
package piso_pkg;
  typedef enum logic {IDLE, SHIFT} state_t;
  function automatic int cnt_width(input int width);
    return $clog2(width);
  endfunction
endpackage

// File: rtl/piso_hold_buf.sv
// piso_hold_buf: one-entry holding register with full flag and ready output
module piso_hold_buf #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr,
  input  logic             rd,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             ready
);
  assign ready = !full;
  always_ff @(posedge clk) begin
    if (rst) full <= 1'b0;
    else full <= wr | (full & ~rd);
  end
  always_ff @(posedge clk) begin
    if (wr) dout <= din;
  end
endmodule

// File: rtl/piso_stream.sv
// piso_stream: parameterised valid/ready serializer with framed, gap-free word streaming
module piso_stream import piso_pkg::*; #(
  parameter int WIDTH      = 8,
  parameter bit LSB_FIRST  = 1'b0,
  parameter bit IDLE_LEVEL = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] parallel_in,
  output logic             in_ready,
  output logic             serial_out,
  output logic             serial_valid,
  output logic             frame_start,
  output logic             frame_last,
  output logic             busy
);
  localparam int CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [WIDTH-1:0] shreg, shreg_n, word, hold_q;
  logic accept, load_sh, shift, hold_wr, hold_rd, hold_full;
  logic out_n, vld_n, start_n, last_n;
  piso_hold_buf #(.WIDTH(WIDTH)) u_hold (
    .clk   (clk),
    .rst   (rst),
    .wr    (hold_wr),
    .rd    (hold_rd),
    .din   (parallel_in),
    .dout  (hold_q),
    .full  (hold_full),
    .ready (in_ready)
  );
  assign accept = load && in_ready;
  assign busy   = (state == SHIFT) || hold_full;
  always_comb begin
    state_n = state;
    load_sh = 1'b0;
    shift   = 1'b0;
    hold_wr = 1'b0;
    hold_rd = 1'b0;
    word    = parallel_in;
    if (state == IDLE) begin
      load_sh = accept;
      state_n = accept ? SHIFT : IDLE;
    end else if (cnt == LAST) begin
      // a buffered word has priority; otherwise a fresh word may bypass the buffer
      if (hold_full) begin
        load_sh = 1'b1;
        hold_rd = 1'b1;
        word    = hold_q;
      end else if (accept) begin
        load_sh = 1'b1;
      end else begin
        state_n = IDLE;
      end
    end else begin
      shift   = 1'b1;
      hold_wr = accept;
    end
    shreg_n = load_sh ? word : shift ? (LSB_FIRST ? shreg >> 1 : shreg << 1) : shreg;
    cnt_n   = shift ? cnt + CW'(1) : '0;
    vld_n   = load_sh || shift;
    out_n   = vld_n ? (LSB_FIRST ? shreg_n[0] : shreg_n[WIDTH-1]) : IDLE_LEVEL;
    start_n = load_sh;
    last_n  = vld_n && (cnt_n == LAST);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      shreg        <= '0;
      serial_out   <= IDLE_LEVEL;
      serial_valid <= 1'b0;
      frame_start  <= 1'b0;
      frame_last   <= 1'b0;
    end else begin
      state        <= state_n;
      cnt          <= cnt_n;
      shreg        <= shreg_n;
      serial_out   <= out_n;
      serial_valid <= vld_n;
      frame_start  <= start_n;
      frame_last   <= last_n;
    end
  end
endmodule

// File: tb/tb_piso_stream.sv
// tb_piso_stream: table-driven and directed checks for MSB/LSB/16-bit serializer variants
module tb_piso_stream;
  typedef struct {
    logic       r;
    logic       l;
    logic [7:0] d;
    logic [5:0] e;
  } vec_t;
  vec_t v[$];
  logic clk = 1'b0, rst = 1'b1;
  logic ld0 = 1'b0, ld1 = 1'b0, ld2 = 1'b0;
  logic [7:0] d0 = '0, d1 = '0;
  logic [15:0] d2 = '0;
  logic rdy0, so0, sv0, fs0, fl0, bz0;
  logic rdy1, so1, sv1, fs1, fl1, bz1;
  logic rdy2, so2, sv2, fs2, fl2, bz2;
  logic [5:0] st0, st1, st2;
  int checks = 0, errors = 0;
  assign st0 = {so0, sv0, fs0, fl0, rdy0, bz0};
  assign st1 = {so1, sv1, fs1, fl1, rdy1, bz1};
  assign st2 = {so2, sv2, fs2, fl2, rdy2, bz2};
  always #5 clk = ~clk;
  piso_stream #(.WIDTH(8), .LSB_FIRST(1'b0), .IDLE_LEVEL(1'b0)) u_msb (
    .clk(clk), .rst(rst), .load(ld0), .parallel_in(d0), .in_ready(rdy0),
    .serial_out(so0), .serial_valid(sv0), .frame_start(fs0), .frame_last(fl0), .busy(bz0));
  piso_stream #(.WIDTH(8), .LSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) u_lsb (
    .clk(clk), .rst(rst), .load(ld1), .parallel_in(d1), .in_ready(rdy1),
    .serial_out(so1), .serial_valid(sv1), .frame_start(fs1), .frame_last(fl1), .busy(bz1));
  piso_stream #(.WIDTH(16), .LSB_FIRST(1'b0), .IDLE_LEVEL(1'b1)) u_w16 (
    .clk(clk), .rst(rst), .load(ld2), .parallel_in(d2), .in_ready(rdy2),
    .serial_out(so2), .serial_valid(sv2), .frame_start(fs2), .frame_last(fl2), .busy(bz2));
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string name, input logic [5:0] act, input logic [5:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%b want=%b", name, act, exp);
    end
  endtask
  function automatic void add(input logic r, input logic l, input logic [7:0] d, input logic [5:0] e);
    v.push_back('{r, l, d, e});
  endfunction
  initial begin
    logic [7:0] lsb_seq;
    logic [15:0] w16_seq;
    lsb_seq = 8'b1101_0011;
    w16_seq = 16'b1010_0101_1111_0000;
    // status bits: {serial_out, serial_valid, frame_start, frame_last, in_ready, busy}
    add(0,1,8'hCB,6'b111011); add(0,0,0,6'b110011); add(0,0,0,6'b010011); add(0,0,0,6'b010011);
    add(0,0,0,6'b110011); add(0,0,0,6'b010011); add(0,0,0,6'b110011); add(0,0,0,6'b110111);
    add(0,0,0,6'b000010);
    add(0,1,8'hCB,6'b111011); add(0,1,8'h5A,6'b110001); add(0,1,8'h3C,6'b010001); add(0,1,8'h3C,6'b010001);
    add(0,1,8'h3C,6'b110001); add(0,1,8'h3C,6'b010001); add(0,1,8'h3C,6'b110001); add(0,1,8'h3C,6'b110101);
    add(0,1,8'h3C,6'b011011); add(0,1,8'h3C,6'b110001); add(0,0,0,6'b010001); add(0,0,0,6'b110001);
    add(0,0,0,6'b110001); add(0,0,0,6'b010001); add(0,0,0,6'b110001); add(0,0,0,6'b010101);
    add(0,0,0,6'b011011); add(0,0,0,6'b010011); add(0,0,0,6'b110011); add(0,0,0,6'b110011);
    add(0,0,0,6'b110011); add(0,0,0,6'b110011); add(0,0,0,6'b010011); add(0,0,0,6'b010111);
    add(0,0,0,6'b000010);
    add(0,1,8'hCB,6'b111011); add(0,1,8'h5A,6'b110001); add(0,1,8'hFF,6'b010001); add(0,0,0,6'b010001);
    add(0,0,0,6'b110001); add(0,0,0,6'b010001); add(0,0,0,6'b110001); add(0,0,0,6'b110101);
    add(0,0,0,6'b011011); add(0,0,0,6'b110011); add(0,0,0,6'b010011); add(0,0,0,6'b110011);
    add(0,0,0,6'b110011); add(0,0,0,6'b010011); add(0,0,0,6'b110011); add(0,0,0,6'b010111);
    add(0,0,0,6'b000010);
    add(0,1,8'hCB,6'b111011); add(0,0,0,6'b110011); add(0,0,0,6'b010011); add(0,0,0,6'b010011);
    add(0,0,0,6'b110011); add(0,0,0,6'b010011); add(0,0,0,6'b110011); add(0,0,0,6'b110111);
    add(0,1,8'h5A,6'b011011); add(0,0,0,6'b110011); add(0,0,0,6'b010011); add(0,0,0,6'b110011);
    add(0,0,0,6'b110011); add(0,0,0,6'b010011); add(0,0,0,6'b110011); add(0,0,0,6'b010111);
    add(0,0,0,6'b000010);
    add(0,1,8'hCB,6'b111011); add(0,1,8'h5A,6'b110001); add(0,0,0,6'b010001); add(0,0,0,6'b010001);
    add(0,0,0,6'b110001); add(1,0,0,6'b000010); add(0,0,0,6'b000010); add(0,0,0,6'b000010);
    add(0,0,0,6'b000010);
    tick;
    tick;
    chk("reset_msb", st0, 6'b000010);
    chk("reset_lsb", st1, 6'b000010);
    chk("reset_w16", st2, 6'b100010);
    rst = 1'b0;
    for (int i = 0; i < v.size(); i++) begin
      rst = v[i].r;
      ld0 = v[i].l;
      d0  = v[i].d;
      tick;
      chk($sformatf("vec%0d", i), st0, v[i].e);
    end
    rst = 1'b0;
    ld0 = 1'b0;
    ld1 = 1'b1;
    d1  = 8'hCB;
    for (int i = 0; i < 8; i++) begin
      tick;
      ld1 = 1'b0;
      chk($sformatf("lsb_bit%0d", i), {2'b00, st1[5:2]}, {2'b00, lsb_seq[7-i], 1'b1, i == 0, i == 7});
    end
    tick;
    chk("lsb_idle", st1, 6'b000010);
    ld2 = 1'b1;
    d2  = 16'hA5F0;
    for (int i = 0; i < 16; i++) begin
      tick;
      ld2 = 1'b0;
      chk($sformatf("w16_bit%0d", i), {2'b00, st2[5:2]}, {2'b00, w16_seq[15-i], 1'b1, i == 0, i == 15});
    end
    tick;
    chk("w16_idle", st2, 6'b100010);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
